seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Display-side consumer of the stopwatch's 32-bit packed BCD time word. It time-multiplexes eight BCD digits onto a common-anode 8-digit seven-segment display: one digit at a time, decoded to segments, with decimal-point separators. It latches the time word once per scan frame so a count changing mid-frame never tears the display. It sits between the BCD counter and the board's anode/cathode pins.

## Interface
- `CLK_DIV`, 100000: clock cycles each digit is selected (one slot); must be ≥ 2.
- `BLANK_CYCLES`, 1: cycles at the start of each slot with all anodes off (anti-ghosting); must be < `CLK_DIV`.

- `clk` in 1: main clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `data` in 32: packed BCD `{h10,h1,m10,m1,s10,s1,t10,t100}`; digit k = `data[4k+3:4k]`.
- `an` out 8: anode enables, active-low, one-hot-low or all-high.
- `seg` out 7: cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal-point cathode, active-low.
- `frame_done` out 1: one-cycle pulse at each snapshot load.

## Operation
- Prescaler `pcnt` counts 0..`CLK_DIV`-1, then wraps to 0. `tick` = (`pcnt`==`CLK_DIV`-1).
- Digit index `idx` (3 bits) increments on `tick`, wrapping 7→0.
- Snapshot register `snap[31:0]` loads `data` on the `tick` where `idx`==7 (frame boundary). It holds otherwise. Display content derives only from `snap`.
- Per-digit decode of `snap` nibble at `idx`:
  - 0→0x40, 1→0x79, 2→0x24, 3→0x30, 4→0x19, 5→0x12, 6→0x02, 7→0x78, 8→0x00, 9→0x10.
  - Any nibble 0xA–0xF→0x3F (dash, g only).
- `dp`=0 when `idx`∈{2,4,6}; `dp`=1 otherwise. This gives the separators hh.mm.ss.tt.
- `an`: all-high while `pcnt` < `BLANK_CYCLES`; otherwise bit `idx` low, others high.
- States are implicit in (`idx`,`pcnt`); there is no other FSM.

## Timing
- Reset values (async assert):
  - `pcnt`=0, `idx`=0, `snap`=0.
  - `an`=8'hFF, `seg`=7'h7F, `dp`=1, `frame_done`=0.
- All outputs are registered. Outputs in cycle n+1 reflect `idx`/`pcnt`/`snap` in cycle n (1-cycle latency).
- After reset deassert, the first frame shows all zeros ("00.00.00.00"). Live `data` first appears at the start of the second frame, 8·`CLK_DIV`+1 cycles after reset release.
- `frame_done` is high for exactly the one cycle after the snapshot-load edge.
- Timing of `data`:
  - `data` changes at any cycle other than the load edge are invisible until the next frame.
  - `data` sampled exactly at the load edge is captured.
- Full frame period = 8·`CLK_DIV` cycles.
- Reset mid-slot or mid-frame: outputs go to reset values asynchronously, and scanning restarts at digit 0 with `snap`=0.

## Configuration
- `SEVSEG_LZ_BLANK_EN` defined: leading-zero blanking for digits 7..3.
  - Digit k (3≤k≤7) is blanked when `snap` digits k..7 are all 0x0.
  - A blanked slot drives `an`=8'hFF, `seg`=7'h7F, `dp`=1.
  - Prescaler and `idx` timing are unchanged.
  - Digits 0–2 are never blanked (minimum "0.00").
- Not defined: all eight digits are always driven, and zeros are shown.

## Test plan
- Reset check: assert `reset` mid-slot with `idx`=5 → `an`=FF, `seg`=7F, `dp`=1, `frame_done`=0 in the same cycle; after release, digit 0 is enabled at cycle `BLANK_CYCLES`+1.
- Scan sequence: `CLK_DIV`=4, `BLANK_CYCLES`=1, `data`=0x12345678 held.
  - Frame 2: `an` low-bit walks FE,FD,…,7F, each low for 3 of every 4 cycles.
  - `seg` = 0x00,0x78,0x02,0x12,0x19,0x30,0x24,0x79.
  - `dp` is low on slots 2, 4, 6.
- Tearing: change `data` from 0x00000000 to 0x99595999 while `idx`=3 → the remainder of the frame shows 0x40 on all digits; the next frame shows the new value; `frame_done` pulses once at the boundary.
- Invalid BCD: `data`=0x0000000A → digit 0 `seg`=0x3F.
- Leading zeros: `data`=0x00000105.
  - With `SEVSEG_LZ_BLANK_EN`: slots 3–7 have `an`=FF.
  - Without it: slots 3–7 show 0x40.
  - In both cases digits 0..2 show 5, 0, 1.
- Wrap: count `idx` through 7→0 for ≥3 frames → `frame_done` period = 32 cycles with `CLK_DIV`=4.

Source files
------------

// File: rtl/seven_seg_scanner.sv
// Eight-digit common-anode seven-segment scanner fed by a packed BCD time word.
// Optional leading-zero blanking of digits 7..3 when SEVSEG_LZ_BLANK_EN is defined.
`timescale 1ns/1ps
module seven_seg_scanner #(
    parameter int CLK_DIV      = 100000,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int            PW       = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_W  = PW'(BLANK_CYCLES);

    logic [PW-1:0] pcnt;
    logic [2:0]    idx;
    logic [31:0]   snap;
    logic          tick;
    logic [3:0]    nibble;
    logic [6:0]    seg_dec;
    logic          digit_blank;
    logic [7:0]    an_next;
    logic [6:0]    seg_next;
    logic          dp_next;

    assign tick   = (pcnt == PCNT_MAX);
    assign nibble = snap[{idx, 2'b00} +: 4];

    // The snapshot only moves at the frame boundary so a mid-frame count never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
            idx  <= 3'd0;
            snap <= 32'h0;
        end else if (tick) begin
            pcnt <= '0;
            idx  <= idx + 3'd1;
            if (idx == 3'd7) begin
                snap <= data;
            end
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    always_comb begin
        seg_dec = 7'h3F;
        case (nibble)
            4'h0:    seg_dec = 7'h40;
            4'h1:    seg_dec = 7'h79;
            4'h2:    seg_dec = 7'h24;
            4'h3:    seg_dec = 7'h30;
            4'h4:    seg_dec = 7'h19;
            4'h5:    seg_dec = 7'h12;
            4'h6:    seg_dec = 7'h02;
            4'h7:    seg_dec = 7'h78;
            4'h8:    seg_dec = 7'h00;
            4'h9:    seg_dec = 7'h10;
            default: seg_dec = 7'h3F;
        endcase
    end

`ifdef SEVSEG_LZ_BLANK_EN
    logic [7:0] lz_mask;
    logic       zero_run;

    // A digit is a leading zero when it and every more-significant digit are zero.
    always_comb begin
        lz_mask  = 8'h00;
        zero_run = 1'b1;
        for (int k = 7; k >= 3; k--) begin
            zero_run   = zero_run & (snap[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    assign digit_blank = lz_mask[idx];
`else
    assign digit_blank = 1'b0;
`endif

    always_comb begin
        an_next  = 8'hFF;
        seg_next = 7'h7F;
        dp_next  = 1'b1;
        if (!digit_blank) begin
            if (pcnt >= BLANK_W) begin
                an_next = ~(8'h01 << idx);
            end
            seg_next = seg_dec;
            dp_next  = !((idx == 3'd2) || (idx == 3'd4) || (idx == 3'd6));
        end
    end

    // One register stage on every pin keeps the outputs glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            an         <= an_next;
            seg        <= seg_next;
            dp         <= dp_next;
            frame_done <= tick && (idx == 3'd7);
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: per-cycle expectations from a time-based
// reference model are queued by the driver and popped by an independent monitor.
`timescale 1ns/1ps
module tb_seven_seg_scanner;

    localparam int CLK_DIV      = 4;
    localparam int BLANK_CYCLES = 1;
    localparam int FRAME        = 8 * CLK_DIV;

    typedef struct {
        int         cyc;
        logic [7:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } expect_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data  = 32'h0;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    expect_t     exp_q[$];
    logic [31:0] hist [0:1023];
    logic [6:0]  seg_tab [0:15];
    int          total = 0;
    int          bad   = 0;

    seven_seg_scanner #(
        .CLK_DIV      (CLK_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected pins in cycle m after reset release, derived from elapsed time alone.
    function automatic expect_t model(input int m);
        expect_t     e;
        logic [31:0] sv;
        int          s, p, i, f, nib;
        e.cyc = m;
        e.an  = 8'hFF;
        e.seg = 7'h7F;
        e.dp  = 1'b1;
        e.fd  = 1'b0;
        if (m == 0) return e;
        s   = m - 1;
        p   = s % CLK_DIV;
        i   = (s / CLK_DIV) % 8;
        f   = s / FRAME;
        sv  = (f == 0) ? 32'h0 : hist[FRAME * f - 1];
        nib = int'((sv >> (4 * i)) & 32'hF);
        e.seg = seg_tab[nib];
        e.dp  = (i == 2 || i == 4 || i == 6) ? 1'b0 : 1'b1;
        e.an  = (p < BLANK_CYCLES) ? 8'hFF : ~(8'h01 << i);
        e.fd  = (m % FRAME == 0);
`ifdef SEVSEG_LZ_BLANK_EN
        if (i >= 3 && (sv >> (4 * i)) == 32'h0) begin
            e.an  = 8'hFF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
        end
`endif
        return e;
    endfunction

    function automatic logic [31:0] genData(input int mode, input int m, input logic [31:0] prev);
        case (mode)
            0:       return 32'h12345678;
            1: begin
                if (m < 44)  return 32'h00000000;
                if (m < 64)  return 32'h99595999;
                if (m < 95)  return 32'h11111111;
                if (m == 95) return 32'h24681357;
                return 32'h00000000;
            end
            2:       return 32'h0000000A;
            3:       return 32'h00000105;
            default: return ($urandom_range(0, 7) == 0) ? $urandom : prev;
        endcase
    endfunction

    task automatic pushReset();
        expect_t e;
        e     = model(0);
        e.cyc = -1;
        exp_q.push_back(e);
    endtask

    // Runs one session from reset release; optionally re-asserts reset at cycle resetAt.
    task automatic applyStimulus(input int ncyc, input int mode, input int resetAt);
        logic [31:0] d;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        d       = genData(mode, 0, 32'h0);
        data    = d;
        hist[0] = d;
        exp_q.push_back(model(0));
        for (int m = 1; m < ncyc; m++) begin
            @(posedge clk);
            #1;
            if (m == resetAt) begin
                reset = 1'b1;
                pushReset();
                break;
            end
            d       = genData(mode, m, d);
            data    = d;
            hist[m] = d;
            exp_q.push_back(model(m));
        end
        if (!reset) begin
            @(posedge clk);
            #1;
            reset = 1'b1;
            pushReset();
        end
        @(posedge clk);
        #1;
        pushReset();
    endtask

    task automatic checkOutput(input expect_t e);
        total++;
        if (an !== e.an || seg !== e.seg || dp !== e.dp || frame_done !== e.fd) begin
            bad++;
            $display("[TB] FAIL pins cyc=%0d got an=%h seg=%h dp=%b fd=%b want an=%h seg=%h dp=%b fd=%b",
                     e.cyc, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        reset = 1'b1;
        data  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        pushReset();

        $display("[TB] scan sequence with mid-slot reset at digit 5");
        applyStimulus(200, 0, 3 * FRAME + 22);
        $display("[TB] tearing and load-edge capture");
        applyStimulus(170, 1, -1);
        $display("[TB] invalid BCD nibble");
        applyStimulus(70, 2, -1);
        $display("[TB] leading zeros");
        applyStimulus(70, 3, -1);
        $display("[TB] random data");
        applyStimulus(400, 4, -1);

        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
